// File: rtl/priority_mutex_if.sv
// priority_mutex_if
// -----------------
// Request/grant bundle between requesters and the priority_mutex arbiter.
//
// Signals:
//   Request     [N-1:0]  one bit per line; held high to keep ownership
//   Grant       [N-1:0]  registered, one-hot or zero
//   Grant_Index [W-1:0]  index of current owner, 0 when idle
//   Busy                 high whenever Grant is non-zero
//   Timeout              one-cycle pulse on the first cycle of a forced hand-over
//
// Protocol: a line raises Request and waits. Ownership begins in the cycle
// its Grant bit is seen high and lasts while Request stays high. Dropping
// Request releases the resource; the drop is sampled on the next rising edge,
// and that same edge may already hand Grant to another line. A granted line
// may lose Grant without dropping Request only through a timeout hand-over,
// which is flagged by Timeout in the first cycle of the new grant.
//
// Modports:
//   master  - requester side (drives Request, observes the rest)
//   slave   - arbiter side (observes Request, drives the rest)
interface priority_mutex_if #(
    parameter int N = 2,
    parameter int W = (N > 2) ? $clog2(N) : 1
);
    logic [N-1:0] Request;
    logic [N-1:0] Grant;
    logic [W-1:0] Grant_Index;
    logic         Busy;
    logic         Timeout;

    modport master (
        output Request,
        input  Grant,
        input  Grant_Index,
        input  Busy,
        input  Timeout
    );

    modport slave (
        input  Request,
        output Grant,
        output Grant_Index,
        output Busy,
        output Timeout
    );
endinterface

// File: rtl/priority_mutex.sv
// priority_mutex
// --------------
// N-line mutex/arbiter granting exclusive ownership of a shared resource.
// Grants are registered and non-preemptive; the only forced hand-over is the
// optional maximum-hold timeout.
//
// Parameters:
//   N            number of request lines (minimum 2)
//   ROUND_ROBIN  0 = fixed priority (index 0 highest)
//                1 = rotating priority, search starts after the last owner
//   MAX_HOLD     0 = unlimited hold; otherwise maximum consecutive grant
//                cycles while some other line is requesting
//
// Ports:
//   Clk    system clock, rising edge
//   Reset  synchronous active-high reset (registered once before use)
//   bus    priority_mutex_if.slave: Request in; Grant, Grant_Index, Busy,
//          Timeout out (all registered)
module priority_mutex #(
    parameter int N           = 2,
    parameter int ROUND_ROBIN = 0,
    parameter int MAX_HOLD    = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    priority_mutex_if.slave  bus
);

    localparam int W  = (N > 2) ? $clog2(N) : 1;
    // Hold counter only needs to reach MAX_HOLD; a 1-bit stub otherwise.
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD);
    localparam logic [W-1:0]  PTR_INIT   = W'(N - 1);

    // Reset is delayed one cycle; state clears while treset_q is high.
    logic          treset_q;

    logic [N-1:0]  grant_q,   grant_d;
    logic [W-1:0]  index_q,   index_d;
    logic          busy_q,    busy_d;
    logic          timeout_q, timeout_d;
    logic [HW-1:0] hold_q,    hold_d;
    logic [W-1:0]  ptr_q,     ptr_d;

    logic          owner_req;
    logic          other_req;
    logic          hold_full;
    logic          force_move;
    logic [N-1:0]  cand;
    logic [W-1:0]  win;

    // Winner of a candidate set. Fixed mode scans 0..N-1; round-robin mode
    // scans ptr+1, ptr+2, ... modulo N, so the last owner is searched last.
    function automatic logic [W-1:0] pick_winner(input logic [N-1:0] c,
                                                 input logic [W-1:0] ptr);
        logic [W-1:0] w;
        logic         found;
        int           idx;
        w     = '0;
        found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            if (ROUND_ROBIN != 0) begin
                idx = (int'(ptr) + i) % N;
            end else begin
                idx = i - 1;
            end
            if (!found && c[idx]) begin
                w     = W'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    always_comb begin
        grant_d   = grant_q;
        index_d   = index_q;
        timeout_d = 1'b0;
        hold_d    = hold_q;
        ptr_d     = ptr_q;

        owner_req  = |(grant_q & bus.Request);
        other_req  = |(bus.Request & ~grant_q);
        hold_full  = (MAX_HOLD > 0) && (hold_q == HOLD_LIMIT);
        // Owner still requests (so this is not a release), has used its full
        // hold budget, and someone else is waiting.
        force_move = owner_req && other_req && hold_full;

        // On a forced move the current owner is masked out of the search.
        cand = force_move ? (bus.Request & ~grant_q) : bus.Request;
        win  = pick_winner(cand, ptr_q);

        if (owner_req && !force_move) begin
            // Hold: grant unchanged, counter creeps up to its ceiling.
            if ((MAX_HOLD > 0) && !hold_full) begin
                hold_d = hold_q + HW'(1);
            end
        end else if (|cand) begin
            // Release or timeout: new owner this edge, no dead cycle.
            grant_d   = {{(N-1){1'b0}}, 1'b1} << win;
            index_d   = win;
            hold_d    = (MAX_HOLD > 0) ? HW'(1) : '0;
            ptr_d     = win;
            timeout_d = force_move;
        end else begin
            grant_d = '0;
            index_d = '0;
            hold_d  = '0;
        end

        busy_d = |grant_d;
    end

    always_ff @(posedge Clk) begin
        treset_q <= Reset;
        if (treset_q) begin
            grant_q   <= '0;
            index_q   <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            hold_q    <= '0;
            ptr_q     <= PTR_INIT;
        end else begin
            grant_q   <= grant_d;
            index_q   <= index_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            hold_q    <= hold_d;
            ptr_q     <= ptr_d;
        end
    end

    assign bus.Grant       = grant_q;
    assign bus.Grant_Index = index_q;
    assign bus.Busy        = busy_q;
    assign bus.Timeout     = timeout_q;

endmodule

// File: tb/tb_priority_mutex.sv
// tb_priority_mutex
// -----------------
// Directed bench for priority_mutex. Four N=4 instances share clock and
// reset, one per configuration:
//   u_fix  fixed priority, unlimited hold
//   u_rr   round robin, unlimited hold
//   u_rrt  round robin, MAX_HOLD=3
//   u_fxt  fixed priority, MAX_HOLD=2
module tb_priority_mutex;

    logic clk;
    logic rst;

    int n_checks;
    int n_errors;

    logic [3:0] exp_q[$];

    priority_mutex_if #(.N(4)) if_fix ();
    priority_mutex_if #(.N(4)) if_rr  ();
    priority_mutex_if #(.N(4)) if_rrt ();
    priority_mutex_if #(.N(4)) if_fxt ();

    priority_mutex #(.N(4), .ROUND_ROBIN(0), .MAX_HOLD(0)) u_fix (
        .Clk(clk), .Reset(rst), .bus(if_fix));
    priority_mutex #(.N(4), .ROUND_ROBIN(1), .MAX_HOLD(0)) u_rr (
        .Clk(clk), .Reset(rst), .bus(if_rr));
    priority_mutex #(.N(4), .ROUND_ROBIN(1), .MAX_HOLD(3)) u_rrt (
        .Clk(clk), .Reset(rst), .bus(if_rrt));
    priority_mutex #(.N(4), .ROUND_ROBIN(0), .MAX_HOLD(2)) u_fxt (
        .Clk(clk), .Reset(rst), .bus(if_fxt));

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- stimulus + scoreboard ----------------
    initial begin
        logic [3:0] e;
        logic [3:0] eg;
        logic       et;

        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        if_fix.Request = '0;
        if_rr.Request  = '0;
        if_rrt.Request = '0;
        if_fxt.Request = '0;

        // Reset takes two edges to reach the outputs.
        tick();
        tick();
        check("rst_fix_grant", 32'(if_fix.Grant), 32'h0);
        check("rst_fix_busy",  32'(if_fix.Busy), 32'h0);
        check("rst_fix_idx",   32'(if_fix.Grant_Index), 32'h0);
        check("rst_rr_grant",  32'(if_rr.Grant), 32'h0);
        check("rst_rrt_grant", 32'(if_rrt.Grant), 32'h0);
        check("rst_rrt_tout",  32'(if_rrt.Timeout), 32'h0);
        check("rst_fxt_grant", 32'(if_fxt.Grant), 32'h0);
        check("rst_fxt_busy",  32'(if_fxt.Busy), 32'h0);
        rst = 1'b0;
        tick();
        tick();

        // ---- fixed priority, no preemption ----
        if_fix.Request = 4'b1010;
        tick();
        check("fix_first_grant", 32'(if_fix.Grant), 32'h2);
        check("fix_first_idx",   32'(if_fix.Grant_Index), 32'h1);
        check("fix_first_busy",  32'(if_fix.Busy), 32'h1);
        if_fix.Request = 4'b1011;
        tick();
        check("fix_nopreempt_a", 32'(if_fix.Grant), 32'h2);
        tick();
        check("fix_nopreempt_b", 32'(if_fix.Grant), 32'h2);
        if_fix.Request = 4'b1001;
        tick();
        check("fix_handover_grant", 32'(if_fix.Grant), 32'h1);
        check("fix_handover_idx",   32'(if_fix.Grant_Index), 32'h0);
        if_fix.Request = 4'b0000;
        tick();
        check("fix_idle_grant", 32'(if_fix.Grant), 32'h0);
        check("fix_idle_busy",  32'(if_fix.Busy), 32'h0);

        // ---- round robin rotation ----
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001);
        if_rr.Request = 4'b1111;
        tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rr_grant_first",  32'(if_rr.Grant), 32'(e));
            check("rr_tout_first",   32'(if_rr.Timeout), 32'h0);
            tick();
            check("rr_grant_second", 32'(if_rr.Grant), 32'(e));
            if_rr.Request = 4'b1111 & ~e;
            tick();
            if_rr.Request = 4'b1111;
        end
        if_rr.Request = 4'b0000;
        tick();
        tick();
        check("rr_idle_grant", 32'(if_rr.Grant), 32'h0);

        // ---- round robin timeout, MAX_HOLD=3, Request=0011 ----
        if_rrt.Request = 4'b0011;
        for (int c = 0; c < 9; c++) begin
            tick();
            eg = (((c / 3) % 2) == 0) ? 4'b0001 : 4'b0010;
            et = ((c % 3) == 0) && (c > 0);
            check("rrt_grant", 32'(if_rrt.Grant), 32'(eg));
            check("rrt_tout",  32'(if_rrt.Timeout), 32'(et));
            check("rrt_idx",   32'(if_rrt.Grant_Index), (eg == 4'b0001) ? 32'h0 : 32'h1);
        end
        if_rrt.Request = 4'b0000;
        tick();
        check("rrt_idle_grant", 32'(if_rrt.Grant), 32'h0);

        // ---- single requester never times out ----
        if_rrt.Request = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("single_grant", 32'(if_rrt.Grant), 32'h4);
            check("single_tout",  32'(if_rrt.Timeout), 32'h0);
        end
        // Owner drops with its hold budget full: plain release, no Timeout.
        if_rrt.Request = 4'b0010;
        tick();
        check("drop_at_limit_grant", 32'(if_rrt.Grant), 32'h2);
        check("drop_at_limit_tout",  32'(if_rrt.Timeout), 32'h0);
        if_rrt.Request = 4'b0000;
        tick();

        // ---- fixed-mode timeout, MAX_HOLD=2 ----
        if_fxt.Request = 4'b1101;
        tick();
        check("fxt_hold1", 32'(if_fxt.Grant), 32'h1);
        tick();
        check("fxt_hold2", 32'(if_fxt.Grant), 32'h1);
        check("fxt_hold2_tout", 32'(if_fxt.Timeout), 32'h0);
        tick();
        check("fxt_forced_grant", 32'(if_fxt.Grant), 32'h4);
        check("fxt_forced_tout",  32'(if_fxt.Timeout), 32'h1);
        check("fxt_forced_idx",   32'(if_fxt.Grant_Index), 32'h2);
        if_fxt.Request = 4'b1001;
        tick();
        check("fxt_back_grant", 32'(if_fxt.Grant), 32'h1);
        check("fxt_back_tout",  32'(if_fxt.Timeout), 32'h0);
        if_fxt.Request = 4'b0000;
        tick();

        // ---- reset mid-grant ----
        if_rr.Request = 4'b0100;
        tick();
        check("mid_pre_grant", 32'(if_rr.Grant), 32'h4);
        rst = 1'b1;
        tick();
        check("mid_edge1_grant", 32'(if_rr.Grant), 32'h4);
        rst = 1'b0;
        if_rr.Request = 4'b1111;
        tick();
        check("mid_edge2_grant", 32'(if_rr.Grant), 32'h0);
        check("mid_edge2_busy",  32'(if_rr.Busy), 32'h0);
        check("mid_edge2_tout",  32'(if_rr.Timeout), 32'h0);
        check("mid_edge2_idx",   32'(if_rr.Grant_Index), 32'h0);
        tick();
        check("mid_restart_grant", 32'(if_rr.Grant), 32'h1);
        check("mid_restart_tout",  32'(if_rr.Timeout), 32'h0);
        if_rr.Request = 4'b0000;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
